// File: rtl/mem_stage.sv
// mem_stage: load/store unit between execute and writeback.
// Holds the pipeline while a data-memory request is outstanding.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              in_valid,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] alu_c,
    input  logic [ADDR_W-1:0] rf_rD2,
    input  logic [4:0]        in_rd,
    input  logic              in_we,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [ADDR_W-1:0] dm_wdata,
    output logic [3:0]        dm_wstrb,
    input  logic              dm_ack,
    input  logic [ADDR_W-1:0] dm_rdata,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              misalign
);

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sdata_q;
    logic [4:0]        rd_q;
    logic              we_q;

    logic              is_acc;
    logic              is_mis;
    logic              accept;
    logic [1:0]        off;
    logic [7:0]        lbyte;
    logic [15:0]       lhalf;
    logic [ADDR_W-1:0] ldata;

    always_comb begin
        is_acc = 1'b0;
        is_mis = 1'b0;
        unique case (mem_op)
            OP_LB, OP_LBU, OP_SB: is_acc = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                is_acc = 1'b1;
                is_mis = alu_c[0];
            end
            OP_LW, OP_SW: begin
                is_acc = 1'b1;
                is_mis = |alu_c[1:0];
            end
            default: ;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && is_acc && !is_mis) state_nx = BUSY;
            BUSY: if (dm_ack) state_nx = IDLE;
        endcase
    end

    // Only aligned accesses reach BUSY, so op_q[3] alone marks a store there.
    always_comb begin
        stall    = (state == BUSY);
        dm_req   = (state == BUSY);
        dm_we    = (state == BUSY) && op_q[3];
        dm_addr  = '0;
        dm_wdata = '0;
        dm_wstrb = 4'b0000;
        if (state == BUSY) begin
            dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
            if (op_q[3]) begin
                unique case (op_q[1:0])
                    2'b01: begin
                        dm_wdata = {4{sdata_q[7:0]}};
                        dm_wstrb = 4'b0001 << off;
                    end
                    2'b10: begin
                        dm_wdata = {2{sdata_q[15:0]}};
                        dm_wstrb = 4'b0011 << off;
                    end
                    default: begin
                        dm_wdata = sdata_q;
                        dm_wstrb = 4'b1111;
                    end
                endcase
            end
        end
    end

    assign off   = addr_q[1:0];
    assign lhalf = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        unique case (off)
            2'd0: lbyte = dm_rdata[7:0];
            2'd1: lbyte = dm_rdata[15:8];
            2'd2: lbyte = dm_rdata[23:16];
            default: lbyte = dm_rdata[31:24];
        endcase
    end

    always_comb begin
        unique case (op_q)
            OP_LB:   ldata = {{(ADDR_W-8){lbyte[7]}}, lbyte};
            OP_LBU:  ldata = {{(ADDR_W-8){1'b0}}, lbyte};
            OP_LH:   ldata = {{(ADDR_W-16){lhalf[15]}}, lhalf};
            OP_LHU:  ldata = {{(ADDR_W-16){1'b0}}, lhalf};
            default: ldata = dm_rdata;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            op_q      <= 4'b0000;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= 5'd0;
            we_q      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= 5'd0;
            out_we    <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            if (accept) begin
                op_q    <= mem_op;
                addr_q  <= alu_c;
                sdata_q <= rf_rD2;
                rd_q    <= in_rd;
                we_q    <= in_we;
                if (!is_acc) begin
                    out_valid <= 1'b1;
                    out_data  <= alu_c;
                    out_rd    <= in_rd;
                    out_we    <= in_we;
                end else if (is_mis) begin
                    out_valid <= 1'b1;
                    misalign  <= 1'b1;
                    out_data  <= alu_c;
                    out_rd    <= in_rd;
                    out_we    <= 1'b0;
                end
            end else if (state == BUSY && dm_ack) begin
                out_valid <= 1'b1;
                out_data  <= op_q[3] ? addr_q : ldata;
                out_rd    <= rd_q;
                out_we    <= we_q && !op_q[3];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a
// variable-latency data-memory responder.
module tb_mem_stage;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] alu_c;
    logic [31:0] rf_rD2;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        misalign;

    mem_stage #(.ADDR_W(32)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .in_valid  (in_valid),
        .mem_op    (mem_op),
        .alu_c     (alu_c),
        .rf_rD2    (rf_rD2),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .stall     (stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .misalign  (misalign)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        bit          chk_data;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int          lat = 1;
    int          bcnt = 0;
    logic [31:0] mem_word = '0;
    logic        auto_ack = 1'b0;
    logic        manual_ack = 1'b0;

    assign dm_ack   = auto_ack | manual_ack;
    assign dm_rdata = mem_word;

    // Memory: ack in the lat-th BUSY cycle of each request.
    always @(negedge cpu_clk) begin
        if (dm_req) begin
            bcnt++;
            auto_ack = (bcnt == lat);
        end else begin
            bcnt = 0;
            auto_ack = 1'b0;
        end
    end

    int          cyc = 0;
    int          ov_cnt = 0;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    int          last_ov = 0;
    int          prev_ov = 0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_wstrb = '0;
    logic        e_we = 1'b0;

    always @(posedge cpu_clk) cyc++;

    always @(negedge cpu_clk) begin
        exp_t e;
        if (stall) stall_cnt++;
        if (dm_req) begin
            req_cnt++;
            check_eq("dm_addr", dm_addr, e_addr);
            check_eq("dm_we", {31'd0, dm_we}, {31'd0, e_we});
            check_eq("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, e_wstrb});
            if (e_we) check_eq("dm_wdata", dm_wdata, e_wdata);
        end
        if (out_valid) begin
            ov_cnt++;
            prev_ov = last_ov;
            last_ov = cyc;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                check_eq("out_we", {31'd0, out_we}, {31'd0, e.we});
                check_eq("misalign", {31'd0, misalign}, {31'd0, e.mis});
                if (e.chk_data) check_eq("out_data", out_data, e.data);
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [3:0] op,
                                               input logic [1:0] o,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * o));
        h = o[1] ? w[31:16] : w[15:0];
        case (op)
            4'b0001: return {{24{b[7]}}, b};
            4'b0100: return {24'd0, b};
            4'b0010: return {{16{h[15]}}, h};
            4'b0101: return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Call away from a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] c,
                         input logic [31:0] d, input logic [4:0] rd,
                         input logic we, input bit push,
                         input logic [31:0] word);
        exp_t e;
        bit   acc, mis, ok;
        int   n;
        acc = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11};
        mis = acc && (((op == 4'd2 || op == 4'd5 || op == 4'd10) && c[0]) ||
                      ((op == 4'd3 || op == 4'd11) && c[1:0] != 2'b00));
        e.rd = rd;
        e.mis = mis;
        e.we = (acc && (op[3] || mis)) ? 1'b0 : we;
        e.chk_data = !mis && !(acc && op[3]);
        e.data = acc ? model_load(op, c[1:0], word) : c;
        if (acc && !mis) begin
            mem_word = word;
            e_addr = {c[31:2], 2'b00};
            e_we = op[3];
            case (op)
                4'd9:  begin e_wdata = {4{d[7:0]}};  e_wstrb = 4'b0001 << c[1:0]; end
                4'd10: begin e_wdata = {2{d[15:0]}}; e_wstrb = 4'b0011 << c[1:0]; end
                4'd11: begin e_wdata = d;            e_wstrb = 4'b1111; end
                default: begin e_wdata = '0;         e_wstrb = 4'b0000; end
            endcase
        end
        if (push) sb_q.push_back(e);
        in_valid = 1'b1;
        mem_op = op;
        alu_c = c;
        rf_rD2 = d;
        in_rd = rd;
        in_we = we;
        n = 0;
        forever begin
            ok = !stall;
            @(posedge cpu_clk);
            #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                check_eq("accept_timeout", {31'd0, stall}, 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
        mem_op = 4'd0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge cpu_clk);
            n++;
        end
        check_eq("drain", sb_q.size(), 32'd0);
    endtask

    logic [3:0] ops[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11};

    initial begin
        int ov0;
        logic [1:0] o;
        cpu_rst = 1'b1;
        in_valid = 1'b0;
        mem_op = '0;
        alu_c = '0;
        rf_rD2 = '0;
        in_rd = '0;
        in_we = 1'b0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_dm_req", {31'd0, dm_req}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_dm_addr", dm_addr, 32'd0);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        stall_cnt = 0;
        issue(4'd0, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 1, 32'd0);
        wait_done();
        check_eq("pt_stall", stall_cnt, 32'd0);

        lat = 3;
        stall_cnt = 0;
        issue(4'd1, 32'h103, 32'd0, 5'd7, 1'b1, 1, 32'h80FF_0000);
        wait_done();
        check_eq("lb_stall", stall_cnt, 32'd3);
        issue(4'd4, 32'h103, 32'd0, 5'd8, 1'b1, 1, 32'h80FF_0000);
        wait_done();

        lat = 2;
        issue(4'd10, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b1, 1, 32'd0);
        wait_done();

        req_cnt = 0;
        issue(4'd3, 32'h301, 32'd0, 5'd4, 1'b1, 1, 32'd0);
        wait_done();
        check_eq("mis_no_req", req_cnt, 32'd0);

        for (int i = 0; i < 16; i++) begin
            lat = $urandom_range(1, 4);
            o = 2'(i);
            if (ops[i % 8][1:0] == 2'b10 || ops[i % 8] == 4'd5) o[0] = 1'b0;
            if (ops[i % 8][1:0] == 2'b11) o = 2'b00;
            issue(ops[i % 8], {22'd0, 4'(i), 4'd0, o}, $urandom,
                  5'(i + 1), 1'b1, 1, $urandom);
            wait_done();
        end

        lat = 3;
        ov0 = ov_cnt;
        issue(4'd3, 32'h400, 32'd0, 5'd6, 1'b1, 1, 32'hA5A5_5A5A);
        issue(4'd0, 32'hCAFE_F00D, 32'd0, 5'd9, 1'b1, 1, 32'd0);
        wait_done();
        repeat (3) @(negedge cpu_clk);
        check_eq("b2b_count", ov_cnt - ov0, 32'd2);
        check_eq("b2b_gap", last_ov - prev_ov, 32'd1);

        lat = 1000;
        ov0 = ov_cnt;
        issue(4'd3, 32'h500, 32'd0, 5'd10, 1'b1, 0, 32'h1111_2222);
        @(posedge cpu_clk);
        #1 cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1 cpu_rst = 1'b0;
        manual_ack = 1'b1;
        @(negedge cpu_clk);
        check_eq("rst_busy_req", {31'd0, dm_req}, 32'd0);
        check_eq("rst_busy_stall", {31'd0, stall}, 32'd0);
        @(posedge cpu_clk);
        #1 manual_ack = 1'b0;
        repeat (4) @(negedge cpu_clk);
        check_eq("rst_busy_no_ov", ov_cnt - ov0, 32'd0);
        check_eq("idle_ack_stall", {31'd0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
